// File: rtl/io_pkg.sv
// Shared types and constants for the push-button input conditioning path.
package io_pkg;

  // Per-channel press/hold tracking state.
  typedef enum logic [1:0] {
    BTN_IDLE = 2'd0,
    BTN_HELD = 2'd1,
    BTN_LONG = 2'd2
  } btn_state_t;

  // Flops in the metastability synchroniser ahead of the integrator.
  localparam int unsigned DBNC_SYNC_STAGES = 2;

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: synchroniser, saturating integrator debouncer,
// press/release edge pulses, long-press / auto-repeat FSM and sticky flag.
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   button_i        - raw asynchronous button input
//   clr_i           - sticky clear strobe (clk domain)
//   level_o         - debounced level
//   press_o         - 1-cycle pulse on debounced rising edge
//   release_o       - 1-cycle pulse on debounced falling edge
//   long_press_o    - 1-cycle pulse LONG_CYCLES after press
//   repeat_o        - 1-cycle auto-repeat pulse every REPEAT_CYCLES after long press
//   sticky_o        - set by press, cleared by clr_i
module button_channel
  import io_pkg::*;
#(
  parameter int unsigned DBNC_MAX      = 1048575,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic button_i,
  input  logic clr_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic repeat_o,
  output logic sticky_o
);

  localparam int unsigned CNT_W  = $clog2(DBNC_MAX + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
  localparam int unsigned REP_W  = $clog2(REPEAT_CYCLES);

  logic [DBNC_SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [HOLD_W-1:0]           hold_q, hold_d;
  logic [REP_W-1:0]            rep_q, rep_d;
  btn_state_t                  state_q, state_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;
  logic repeat_q, repeat_d;
  logic sticky_q, sticky_d;

  logic sync_out;
  logic rise;
  logic fall;

  assign sync_out = sync_q[DBNC_SYNC_STAGES-1];
  // Level transitions are judged on the registered integrator value.
  assign rise = (cnt_q == CNT_W'(DBNC_MAX)) && !level_q;
  assign fall = (cnt_q == CNT_W'(0)) && level_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      rep_q     <= '0;
      state_q   <= BTN_IDLE;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      state_q   <= state_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      sticky_q  <= sticky_d;
    end
  end

  // Next-state logic.
  always_comb begin
    sync_d    = {sync_q[DBNC_SYNC_STAGES-2:0], button_i};
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    state_d   = state_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    sticky_d  = sticky_q;

    // Saturating integrator: never wraps in either direction.
    if (sync_out && (cnt_q != CNT_W'(DBNC_MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!sync_out && (cnt_q != CNT_W'(0))) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (rise) begin
      level_d = 1'b1;
      press_d = 1'b1;
    end
    if (fall) begin
      level_d   = 1'b0;
      release_d = 1'b1;
    end

    // Press sets, clear only acts when no press on the same edge.
    if (rise) begin
      sticky_d = 1'b1;
    end else if (clr_i) begin
      sticky_d = 1'b0;
    end

    // Release pre-empts any long/repeat threshold on the same edge.
    if (fall) begin
      state_d = BTN_IDLE;
      hold_d  = '0;
      rep_d   = '0;
    end else begin
      case (state_q)
        BTN_IDLE: begin
          if (rise) begin
            state_d = BTN_HELD;
            hold_d  = '0;
          end
        end
        BTN_HELD: begin
          if (hold_q == HOLD_W'(LONG_CYCLES - 1)) begin
            long_d  = 1'b1;
            state_d = BTN_LONG;
            hold_d  = '0;
            rep_d   = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        BTN_LONG: begin
          if (rep_q == REP_W'(REPEAT_CYCLES - 1)) begin
            repeat_d = REPEAT_EN;
            rep_d    = '0;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end
        default: begin
          state_d = BTN_IDLE;
          hold_d  = '0;
          rep_d   = '0;
        end
      endcase
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_press_o = long_q;
  assign repeat_o     = repeat_q;
  assign sticky_o     = sticky_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: N_CH independent button_channel
// instances whose outputs are gathered into per-function vectors.
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   button_i      - raw asynchronous button inputs
//   clr_i         - per-channel sticky clear strobes
//   level_o       - debounced levels
//   press_o       - press pulses
//   release_o     - release pulses
//   long_press_o  - long-press pulses
//   repeat_o      - auto-repeat pulses
//   sticky_o      - sticky pressed flags
module button_conditioner #(
  parameter int unsigned N_CH          = 5,
  parameter int unsigned DBNC_MAX      = 1048575,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button_i,
  input  logic [N_CH-1:0] clr_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_press_o,
  output logic [N_CH-1:0] repeat_o,
  output logic [N_CH-1:0] sticky_o
);

  // One fully independent conditioner per button.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    button_channel #(
      .DBNC_MAX     (DBNC_MAX),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN    (REPEAT_EN)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .button_i    (button_i[g]),
      .clr_i       (clr_i[g]),
      .level_o     (level_o[g]),
      .press_o     (press_o[g]),
      .release_o   (release_o[g]),
      .long_press_o(long_press_o[g]),
      .repeat_o    (repeat_o[g]),
      .sticky_o    (sticky_o[g])
    );
  end

endmodule
